// File: rtl/spi_arb_pkg.sv
// Shared types and default sizing for the SPI TX burst arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_LEN_WIDTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/spi_tx_burst_arbiter_rr_picker.sv
// Round-robin select: first set request at or above ptr, wrapping to bit 0.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          found
);

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_burst_arbiter.sv
// Round-robin burst arbiter sharing one SPI TX FIFO write port; optional stall timeout under SPI_ARB_TIMEOUT_EN.
// Latency: first FIFO write 2 cycles after req_valid is seen in IDLE, then 1 word/cycle; 2 dead cycles between bursts.
// Backpressure: fifo_full stalls the owner (no write, no count); only the owner ever sees req_data_ready.
module spi_tx_burst_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                            ACLK,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_data_valid,
    output logic [NUM_REQ-1:0]              req_data_ready,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              burst_done,
    output logic [NUM_REQ-1:0]              burst_abort,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic                            busy
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("spi_tx_burst_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t           state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        owner;
    logic [LEN_WIDTH-1:0] cnt;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic [LEN_WIDTH-1:0] pick_len;
    logic                 in_xfer;
    logic                 owner_vld;
    logic                 accept;
    logic                 timeout;
    logic [PW-1:0]        next_ptr;

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    // Encode the picked one-hot into an index and fetch that requester's length.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) pick_idx = PW'(i);
        end
        pick_len = req_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];
    end

    assign in_xfer        = (state == XFER);
    assign owner_vld      = req_data_valid[owner];
    assign accept         = in_xfer & owner_vld & ~fifo_full;
    assign fifo_wr_en     = accept;
    assign fifo_data      = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
    assign req_data_ready = (in_xfer & ~fifo_full) ? (NUM_REQ'(1) << owner) : '0;
    assign busy           = (state != IDLE);
    assign next_ptr       = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_cnt;
    logic          stall;

    // Only owner-source starvation counts; FIFO-full cycles are legitimate waits.
    assign stall   = in_xfer & ~owner_vld & ~fifo_full;
    assign timeout = stall & (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

    // Stall counter: cleared outside XFER and on every accepted word.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!in_xfer || accept) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Arbitration FSM with registered grant, word counter and done/abort pulses.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            cnt         <= '0;
            rr_ptr      <= '0;
            burst_done  <= '0;
            burst_abort <= '0;
        end else begin
            burst_done  <= '0;
            burst_abort <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_gnt;
                        owner <= pick_idx;
                        cnt   <= pick_len;
                        state <= GRANT;
                    end
                end
                GRANT: state <= XFER;
                XFER: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            state      <= IDLE;
                            grant      <= '0;
                            burst_done <= grant;
                            rr_ptr     <= next_ptr;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end else if (timeout) begin
                        state       <= IDLE;
                        grant       <= '0;
                        burst_abort <= grant;
                        rr_ptr      <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
